// File: rtl/rv32i_regfile_dbg_arb.sv
// Debug-port arbiter for the RV32I register file.
// Normally, the register file port passes straight through to the core pipeline.
// A debug request first freezes the pipeline. It then waits for the register
// file's write bypass to drain, makes one read or write access, and pulses
// dbg_ack when the access is done.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | core owns the register file, rf_* = core_*
// DRAIN  | core held, waiting for in-flight write-backs to settle
// ACCESS | debug drives the register file (write strobe or read index)
// RDWAIT | read index held, read data captured at the end of this cycle
// RESP   | dbg_ack pulse, back to IDLE unconditionally
module rv32i_regfile_dbg_arb #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  core_rs1_idx,
    input  logic [4:0]  core_rs2_idx,
    input  logic [4:0]  core_rd_idx,
    input  logic [31:0] core_new_rd,
    input  logic        core_stall,
    input  logic        core_update_pc,
    output logic [4:0]  rf_rs1_idx,
    output logic [4:0]  rf_rs2_idx,
    output logic [4:0]  rf_rd_idx,
    output logic [31:0] rf_new_rd,
    output logic        rf_stall,
    output logic        rf_update_pc,
    input  logic [31:0] rf_rs1,
    output logic        core_hold,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        ACCESS = 3'd2,
        RDWAIT = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        passthru;

    // Next-state logic: captures the request and runs the drain/access/response sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_INIT;
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                end
            end
            DRAIN: begin
                // Dropping the request while draining aborts cleanly; nothing has touched the RF yet.
                if (!dbg_req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: state_d = we_q ? RESP : RDWAIT;
            RDWAIT: begin
                rdata_d = rf_rs1;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Register-file port mux: passthrough in IDLE (and while reset is asserted), debug override otherwise.
    always_comb begin
        passthru     = !reset_n || (state_q == IDLE);
        rf_rs1_idx   = core_rs1_idx;
        rf_rs2_idx   = core_rs2_idx;
        rf_rd_idx    = core_rd_idx;
        rf_new_rd    = core_new_rd;
        rf_stall     = core_stall;
        rf_update_pc = core_update_pc;
        core_hold    = 1'b0;
        dbg_ack      = 1'b0;
        if (!passthru) begin
            core_hold    = 1'b1;
            rf_update_pc = 1'b0;
            rf_rd_idx    = 5'd0;
            rf_stall     = 1'b1;
            case (state_q)
                ACCESS: begin
                    if (we_q) begin
                        // Address 0 flows through as-is, so an x0 write stays a no-op.
                        rf_rd_idx = addr_q;
                        rf_new_rd = wdata_q;
                        rf_stall  = 1'b0;
                    end else begin
                        rf_rs1_idx = addr_q;
                    end
                end
                RDWAIT:  rf_rs1_idx = addr_q;
                RESP:    dbg_ack = 1'b1;
                default: ;
            endcase
        end
    end

    assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_rv32i_regfile_dbg_arb.sv
// Scoreboard bench for rv32i_regfile_dbg_arb.
// A behavioural register file stub sits on the rf_* side. Each debug
// transaction pushes its expected ack cycle and read data. A monitor pops and
// compares them on every dbg_ack.
module tb_rv32i_regfile_dbg_arb;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  core_rs1_idx, core_rs2_idx, core_rd_idx;
    logic [31:0] core_new_rd;
    logic        core_stall, core_update_pc;
    logic [4:0]  rf_rs1_idx, rf_rs2_idx, rf_rd_idx;
    logic [31:0] rf_new_rd;
    logic        rf_stall, rf_update_pc;
    logic [31:0] rf_rs1;
    logic        core_hold;
    logic        dbg_req, dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    rv32i_regfile_dbg_arb #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_rs1_idx(core_rs1_idx), .core_rs2_idx(core_rs2_idx), .core_rd_idx(core_rd_idx),
        .core_new_rd(core_new_rd), .core_stall(core_stall), .core_update_pc(core_update_pc),
        .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx), .rf_rd_idx(rf_rd_idx),
        .rf_new_rd(rf_new_rd), .rf_stall(rf_stall), .rf_update_pc(rf_update_pc),
        .rf_rs1(rf_rs1), .core_hold(core_hold),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file stub: x0 hardwired, write when not stalled, registered RS1 read.
    logic [31:0] regs [32];
    initial for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    always @(posedge clk) begin
        if (!rf_stall && rf_rd_idx != 5'd0) regs[rf_rd_idx] <= rf_new_rd;
        rf_rs1 <= regs[rf_rs1_idx];
    end

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] last_rd = 32'd0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (dbg_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 required=0 cyc=%0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ack_cycle", cyc, mon_e.ack_cyc);
                chk(mon_e.is_rd ? "read_data" : "rdata_hold", dbg_rdata, mon_e.rdata);
            end
        end
    end

    // Issue one debug transaction, check per-cycle port behaviour, wait for its ack.
    task automatic txn(input bit we, input logic [4:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit keep_req);
        exp_t e;
        int   k, rel;
        bit   got;
        @(posedge clk); #1;
        k         = cyc;
        e.is_rd   = !we;
        e.rdata   = we ? last_rd : exp_rd;
        e.ack_cyc = k + D + (we ? 2 : 3);
        if (!we) last_rd = exp_rd;
        sb_q.push_back(e);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = wd;
        got = 1'b0;
        rel = 0;
        while (!got && rel < 40) begin
            @(negedge clk);
            rel = cyc - k;
            if (rel == 0) begin
                chk("idle_hold", core_hold, 1'b0);
                chk("idle_upd_pc", rf_update_pc, core_update_pc);
            end else begin
                chk("hold", core_hold, 1'b1);
                chk("hold_upd_pc", rf_update_pc, 1'b0);
                if (we && rel == D + 1) begin
                    chk("wr_rd_idx", rf_rd_idx, a);
                    chk("wr_stall", rf_stall, 1'b0);
                    chk("wr_data", rf_new_rd, wd);
                end else begin
                    chk("hold_stall", rf_stall, 1'b1);
                    chk("hold_rd_idx", rf_rd_idx, 5'd0);
                end
                if (!we && (rel == D + 1 || rel == D + 2)) chk("rd_rs1_idx", rf_rs1_idx, a);
            end
            if (dbg_ack === 1'b1) begin
                got = 1'b1;
                if (!keep_req) dbg_req = 1'b0;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout actual=none required=ack cyc=%0d", cyc);
            dbg_req = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int k0;

    initial begin
        reset_n = 1'b0;
        core_rs1_idx = 5'd0; core_rs2_idx = 5'd0; core_rd_idx = 5'd0;
        core_new_rd = 32'd0; core_stall = 1'b1; core_update_pc = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;

        // Reset state and passthrough during reset
        repeat (3) @(posedge clk);
        #1 core_rd_idx = 5'd9;
        @(negedge clk);
        chk("rst_hold", core_hold, 1'b0);
        chk("rst_ack", dbg_ack, 1'b0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_pass_rd", rf_rd_idx, 5'd9);
        @(posedge clk); #1;
        reset_n = 1'b1;
        core_rd_idx = 5'd0;

        // Idle passthrough
        @(posedge clk); #1;
        core_rd_idx = 5'd5; core_new_rd = 32'h1234; core_stall = 1'b0;
        core_update_pc = 1'b1; core_rs1_idx = 5'd10; core_rs2_idx = 5'd11;
        @(negedge clk);
        chk("pass_rd_idx", rf_rd_idx, 5'd5);
        chk("pass_new_rd", rf_new_rd, 32'h1234);
        chk("pass_stall", rf_stall, 1'b0);
        chk("pass_upd_pc", rf_update_pc, 1'b1);
        chk("pass_rs1", rf_rs1_idx, 5'd10);
        chk("pass_rs2", rf_rs2_idx, 5'd11);
        chk("pass_hold", core_hold, 1'b0);
        @(posedge clk); #1;
        core_rd_idx = 5'd0; core_stall = 1'b1; core_update_pc = 1'b0;
        core_rs1_idx = 5'd0; core_rs2_idx = 5'd0;

        // Write then read back, reads of x0, write to x0
        txn(1'b1, 5'd3, 32'hDEADBEEF, 32'd0, 1'b0);
        @(negedge clk);
        chk("post_wr_hold", core_hold, 1'b0);
        txn(1'b0, 5'd3, 32'd0, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 5'd0, 32'd0, 32'h0, 1'b0);
        txn(1'b1, 5'd0, 32'h55555555, 32'd0, 1'b0);
        txn(1'b0, 5'd3, 32'd0, 32'hDEADBEEF, 1'b0);
        txn(1'b1, 5'd4, 32'hA5A5A5A5, 32'd0, 1'b0);
        txn(1'b0, 5'd4, 32'd0, 32'hA5A5A5A5, 1'b0);

        // Abort in the second drain cycle
        @(posedge clk); #1;
        k0 = cyc;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h77;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_drain1_hold", core_hold, 1'b1);
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("abort_drain2_stall", rf_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_cycle", cyc, k0 + 3);
        chk("abort_hold", core_hold, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_no_ack", dbg_ack, 1'b0);
        txn(1'b0, 5'd7, 32'd0, 32'h0, 1'b0);

        // Back-to-back reads with the request held and core_update_pc asserted
        txn(1'b1, 5'd1, 32'h11111111, 32'd0, 1'b0);
        txn(1'b1, 5'd2, 32'h22222222, 32'd0, 1'b0);
        core_update_pc = 1'b1;
        txn(1'b0, 5'd1, 32'd0, 32'h11111111, 1'b1);
        txn(1'b0, 5'd2, 32'd0, 32'h22222222, 1'b0);
        core_update_pc = 1'b0;

        // Reset during RDWAIT
        @(posedge clk); #1;
        k0 = cyc;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rdwait_rs1_idx", rf_rs1_idx, 5'd3);
        chk("rdwait_cycle", cyc, k0 + 4);
        reset_n = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("rst_mid_hold", core_hold, 1'b0);
        chk("rst_mid_ack", dbg_ack, 1'b0);
        chk("rst_mid_rdata", dbg_rdata, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
        chk("rst_after_hold", core_hold, 1'b0);
        chk("rst_after_rdata", dbg_rdata, 32'd0);
        chk("rst_after_ack", dbg_ack, 1'b0);

        // Normal operation after the mid-transaction reset
        txn(1'b1, 5'd6, 32'hCAFEF00D, 32'd0, 1'b0);
        txn(1'b0, 5'd3, 32'd0, 32'hDEADBEEF, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_regfile_dbg_arb.md
RV32I_REGFILE_DBG_ARB -- requirements
Module: rv32i_regfile_dbg_arb

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: number of cycles the core is held before debug access, covering the regfile's 2-deep write bypass; legal range 1..15.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 core_rs1_idx, core_rs2_idx, core_rd_idx  input  5 each  pipeline register indices.
REQ-005 core_new_rd  input  32  pipeline write-back data.
REQ-006 core_stall  input  1  pipeline stall request.
REQ-007 core_update_pc  input  1  pipeline PC-update request.
REQ-008 rf_rs1_idx, rf_rs2_idx, rf_rd_idx  output  5 each  indices to register file.
REQ-009 rf_new_rd  output  32  write data to register file.
REQ-010 rf_stall, rf_update_pc  output  1 each  stall / PC update to register file.
REQ-011 rf_rs1  input  32  register file RS1 read data, valid one cycle after index presented.
REQ-012 core_hold  output  1  freezes pipeline while debug owns the register file.
REQ-013 dbg_req, dbg_we  input  1 each  debug request; 1=write, 0=read.
REQ-014 dbg_addr  input  5  debug register index.
REQ-015 dbg_wdata  input  32  debug write data.
REQ-016 dbg_ack  output  1  one-cycle completion pulse.
REQ-017 dbg_rdata  output  32  read result, valid while dbg_ack=1.

Function
REQ-018 FSM states SHALL be IDLE, DRAIN, ACCESS, RDWAIT, RESP; state is registered.
REQ-019 IDLE: all rf_* outputs equal corresponding core_* inputs (rf_stall=core_stall, rf_update_pc=core_update_pc); core_hold=0; dbg_ack=0.
REQ-020 IDLE with dbg_req=1 at an edge -> DRAIN; dbg_we, dbg_addr, dbg_wdata captured into internal registers at that edge; drain counter loaded with DRAIN_CYCLES-1.
REQ-021 All non-IDLE states: core_hold=1, rf_update_pc=0, rf_rd_idx=0 and rf_stall=1 except as in REQ-023.
REQ-022 DRAIN: counter decrements each cycle; at counter=0 -> ACCESS; if dbg_req=0 at any DRAIN edge -> IDLE, no access, no ack (abort).
REQ-023 ACCESS, write: rf_rd_idx=captured addr, rf_new_rd=captured wdata, rf_stall=0 for this cycle only -> RESP next edge.
REQ-024 ACCESS, write to x0: rf_rd_idx=0 (no write), still -> RESP and acked.
REQ-025 ACCESS, read: rf_rs1_idx=captured addr -> RDWAIT; RDWAIT keeps rf_rs1_idx=captured addr; at RDWAIT edge rf_rs1 captured into dbg_rdata register -> RESP.
REQ-026 RESP: dbg_ack=1 for exactly one cycle -> IDLE unconditionally; dbg_req ignored from ACCESS onward (no abort after ACCESS).
REQ-027 dbg_rdata SHALL hold last read value until next read completes; write completions leave it unchanged.
REQ-028 Latency from edge sampling dbg_req in IDLE to dbg_ack high: write DRAIN_CYCLES+2 cycles, read DRAIN_CYCLES+3 cycles.
REQ-029 After RESP at least one IDLE cycle occurs; dbg_req still high in that cycle starts a new transaction (back-to-back permitted).
REQ-030 core_stall/core_update_pc asserted during non-IDLE states are not queued; pipeline re-presents them when core_hold drops.

Reset
REQ-031 reset_n=0 at an edge -> state IDLE, counter 0, dbg_ack=0, dbg_rdata=0, captured registers 0, core_hold=0, regardless of current state (reset mid-transaction discards it, no ack).
REQ-032 During reset rf_* outputs follow the IDLE passthrough of REQ-019.

Verification
REQ-033 IDLE, core_rd_idx=5, core_new_rd=0x1234 -> rf_rd_idx=5, rf_new_rd=0x1234 same cycle, core_hold=0.
REQ-034 DRAIN_CYCLES=2, write addr 3 data 0xDEADBEEF -> core_hold 4 cycles, rf_rd_idx=3/rf_stall=0 in cycle 3, dbg_ack in cycle 4, subsequent read addr 3 returns 0xDEADBEEF.
REQ-035 Read addr 0 -> dbg_ack 5 cycles after request, dbg_rdata=0x00000000; write to x0 acked with rf_rd_idx=0 throughout.
REQ-036 dbg_req dropped in second DRAIN cycle -> return to IDLE, no dbg_ack, no rf write, core_hold=0 next cycle.
REQ-037 reset_n=0 during RDWAIT -> IDLE next cycle, dbg_ack never pulses, dbg_rdata=0.
REQ-038 dbg_req held high across two reads (addr 1 then 2) -> two acks separated by exactly one IDLE cycle plus full latency; core_update_pc=1 during hold -> rf_update_pc stays 0.
